// File: rtl/aud_player_stereo.sv
// Stereo I2S-style DAC player: buffers one stereo frame, then serializes the
// left and right samples MSB first into the slots framed by i_daclrck.
// A missing frame at the start of a left slot plays silence and is counted.

module aud_player_stereo #(
    parameter int DATA_W = 16,
    parameter int SLOT_W = 16,
    parameter int UNDR_W = 8
) (
    input  logic              i_bclk,
    input  logic              i_rst,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic              i_mute,
    input  logic              i_mono,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_ready,
    output logic              o_aud_dacdat,
    output logic              o_underrun,
    output logic [UNDR_W-1:0] o_undr_cnt
);

    // The bit counter is sized for the longest slot, which covers DATA_W too.
    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] BITS_AFTER_MSB = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               lrck_d;
    logic               lrck_fall;
    logic               lrck_rise;
    logic               enter_left;
    logic               enter_right;
    logic [DATA_W-1:0]  buf_l;
    logic [DATA_W-1:0]  buf_r;
    logic               buf_full;
    logic [DATA_W-1:0]  play_r;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bits_left;
    logic [DATA_W-1:0]  left_slot;
    logic [DATA_W-1:0]  right_slot;

    assign lrck_fall = lrck_d & ~i_daclrck;
    assign lrck_rise = ~lrck_d & i_daclrck;

    // Mute and mono are folded into the frame values here, so they are only
    // ever captured at the start of a left slot and stay fixed for the frame.
    always_comb begin
        left_slot  = '0;
        right_slot = '0;
        if (buf_full && !i_mute) begin
            left_slot  = buf_l;
            right_slot = i_mono ? buf_l : buf_r;
        end
    end

    // Slot sequencing; rising edges in IDLE are ignored so playback starts left.
    always_comb begin
        state_next  = state;
        enter_left  = 1'b0;
        enter_right = 1'b0;
        case (state)
            IDLE: begin
                if (lrck_fall && i_en) begin
                    state_next = LEFT;
                    enter_left = 1'b1;
                end
            end
            LEFT: begin
                if (lrck_rise) begin
                    state_next  = RIGHT;
                    enter_right = 1'b1;
                end
            end
            RIGHT: begin
                if (lrck_fall) begin
                    if (i_en) begin
                        state_next = LEFT;
                        enter_left = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_bclk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Delayed LRCK for edge detection.
    always_ff @(posedge i_bclk) begin
        if (i_rst) lrck_d <= 1'b0;
        else       lrck_d <= i_daclrck;
    end

    // One-entry frame buffer; draining at a left slot start takes priority, so
    // a frame offered on that cycle waits for o_ready to rise the next cycle.
    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            buf_l    <= '0;
            buf_r    <= '0;
            buf_full <= 1'b0;
            o_ready  <= 1'b1;
        end else if (enter_left && buf_full) begin
            buf_full <= 1'b0;
            o_ready  <= 1'b1;
        end else if (i_valid && o_ready) begin
            buf_l    <= i_left;
            buf_r    <= i_right;
            buf_full <= 1'b1;
            o_ready  <= 1'b0;
        end
    end

    // Underrun pulse and saturating counter for left slots with no frame.
    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            o_underrun <= 1'b0;
            o_undr_cnt <= '0;
        end else begin
            o_underrun <= enter_left && !buf_full;
            if (enter_left && !buf_full && (o_undr_cnt != {UNDR_W{1'b1}})) begin
                o_undr_cnt <= o_undr_cnt + UNDR_W'(1);
            end
        end
    end

    // Serializer: the MSB goes out the cycle after a slot starts, then one bit
    // per cycle, zero padding once DATA_W bits are out; a new slot truncates.
    always_ff @(posedge i_bclk) begin
        if (i_rst) begin
            play_r       <= '0;
            shreg        <= '0;
            bits_left    <= '0;
            o_aud_dacdat <= 1'b0;
        end else if (enter_left) begin
            play_r       <= right_slot;
            o_aud_dacdat <= left_slot[DATA_W-1];
            shreg        <= left_slot << 1;
            bits_left    <= BITS_AFTER_MSB;
        end else if (enter_right) begin
            o_aud_dacdat <= play_r[DATA_W-1];
            shreg        <= play_r << 1;
            bits_left    <= BITS_AFTER_MSB;
        end else if (state_next == IDLE) begin
            o_aud_dacdat <= 1'b0;
            bits_left    <= '0;
        end else if (bits_left != '0) begin
            o_aud_dacdat <= shreg[DATA_W-1];
            shreg        <= shreg << 1;
            bits_left    <= bits_left - CNT_W'(1);
        end else begin
            o_aud_dacdat <= 1'b0;
        end
    end

endmodule

// File: doc/aud_player_stereo.md
AUD_PLAYER_STEREO -- requirements
Module: aud_player_stereo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits (legal range 8..32).
REQ-002 SHALL have parameter SLOT_W, default 16, meaning i_bclk cycles per LRCK half-period (legal range DATA_W..64).
REQ-003 SHALL have parameter UNDR_W, default 8, meaning underrun counter width.
REQ-004 SHALL have port i_bclk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port i_daclrck  input  1  meaning channel select: 0 = left slot, 1 = right slot.
REQ-007 SHALL have port i_en  input  1  meaning playback enable.
REQ-008 SHALL have port i_mute  input  1  meaning mute the output while frames are still consumed.
REQ-009 SHALL have port i_mono  input  1  meaning play the left sample in both slots.
REQ-010 SHALL have port i_valid  input  1  meaning a stereo frame is offered.
REQ-011 SHALL have port i_left  input  DATA_W  meaning left sample, two's complement.
REQ-012 SHALL have port i_right  input  DATA_W  meaning right sample, two's complement.
REQ-013 SHALL have port o_ready  output  1  meaning the holding buffer is empty and can accept a frame.
REQ-014 SHALL have port o_aud_dacdat  output  1  meaning serial DAC data, MSB first.
REQ-015 SHALL have port o_underrun  output  1  meaning a one-cycle pulse when a left slot starts with no frame available.
REQ-016 SHALL have port o_undr_cnt  output  UNDR_W  meaning the saturating underrun count.

Function
REQ-017 SHALL register i_daclrck into lrck_d each cycle; falling edge = lrck_d 1 and i_daclrck 0; rising edge = lrck_d 0 and i_daclrck 1.
REQ-018 SHALL hold a one-entry frame buffer (left and right samples plus a full flag); o_ready = not full, driven from a register only.
REQ-019 SHALL accept a frame on a cycle with i_valid=1 and o_ready=1; the frame is stored and o_ready goes low from the next cycle.
REQ-020 SHALL implement states IDLE, LEFT and RIGHT: IDLE->LEFT on a falling edge with i_en=1; LEFT->RIGHT on a rising edge; RIGHT->LEFT on a falling edge with i_en=1; RIGHT->IDLE on a falling edge with i_en=0.
REQ-021 SHALL ignore rising edges in IDLE, so playback always begins on a left slot.
REQ-022 At each transition into LEFT, SHALL load the play registers from the buffer and clear the full flag if the buffer is full.
REQ-023 If the buffer is full on the same cycle a frame is offered, SHALL not accept the offered frame that cycle; o_ready rises the next cycle.
REQ-024 If the buffer is empty on entering LEFT, SHALL load zeros for both slots, pulse o_underrun for exactly 1 cycle, and increment o_undr_cnt, saturating at all-ones.
REQ-025 SHALL sample i_mute and i_mono only on entry to LEFT and hold them for the whole frame; mute forces both slots to zero and still consumes the frame.
REQ-026 When mono is latched, SHALL play the latched left sample in the right slot; the right sample is discarded.
REQ-027 On a slot-start cycle N, SHALL load a DATA_W shift register with the slot sample; o_aud_dacdat presents the MSB in cycle N+1 and shifts one bit per cycle, MSB first.
REQ-028 After DATA_W bits within a slot, SHALL drive 0 until the next slot starts; this holds whenever SLOT_W > DATA_W.
REQ-029 On an LRCK edge arriving before DATA_W bits have shifted, SHALL truncate the remaining bits and start the new slot immediately.
REQ-030 SHALL drive o_aud_dacdat = 0 in IDLE.
REQ-031 SHALL drive o_aud_dacdat directly from a flip-flop, with no combinational path from any input.
REQ-032 Deasserting i_en mid-frame SHALL let the current left and right slots finish; the block then returns to IDLE at the next falling edge without consuming the buffer or counting an underrun.

Reset
REQ-033 While i_rst=1 on a clock edge, SHALL set state IDLE, lrck_d 0, buffer empty, o_ready 1 (visible the cycle after reset), play and shift registers 0, o_aud_dacdat 0, o_underrun 0, o_undr_cnt 0.
REQ-034 Reset asserted mid-slot SHALL abort serialization and discard the buffered frame; the first slot after reset requires a new falling edge of i_daclrck.

Verification
REQ-035 Basic stereo: DATA_W=SLOT_W=16, frame L=16'hA5F0, R=16'h0F0F, i_en=1 -> left bits 1010_0101_1111_0000 starting one cycle after the falling edge, then right bits 0000_1111_0000_1111, no underrun.
REQ-036 Underrun: no frame offered across 3 frames -> o_aud_dacdat stays 0, three single-cycle o_underrun pulses, o_undr_cnt=3; with UNDR_W=2 and 5 frames, count saturates at 3.
REQ-037 Mute/mono: L=16'h8001, R=16'h7FFF, i_mono=1 -> both slots carry 8001; repeat with i_mute=1 -> all zeros and o_ready returns to 1.
REQ-038 Padding/truncation: SLOT_W=24, DATA_W=16 -> 16 data bits then 8 zeros; a short slot of 10 bclk -> only the top 10 bits appear, then the next slot starts.
REQ-039 Handshake back-pressure: i_valid held high with changing data -> exactly one frame accepted per LRCK frame, no frame lost or duplicated; reset mid-right-slot -> output 0 next cycle and o_ready=1.
